// File: rtl/crc32.sv
// Byte-serial reflected CRC-32 accumulator (IEEE 802.3 / gzip / zlib).
// Absorbs one byte per qualified clock and presents the finalized CRC continuously.
module crc32 #(
    parameter logic [31:0] POLY    = 32'hEDB88320,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  crc32_in,
    input  logic        crc32_valid_in,
    output logic [31:0] crc32_out
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // LSB-first bitwise update, unrolled over the eight data bits.
    function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] d_in);
        logic [31:0] c;
        logic [7:0]  d;
        logic        fb;
        c = c_in;
        d = d_in;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[0] ^ d[0];
            c  = (c >> 1) ^ (fb ? POLY : '0);
            d  = d >> 1;
        end
        return c;
    endfunction

    always_comb begin
        crc_d = crc_next(crc_q, crc32_in);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= INIT;
        end else if (crc32_valid_in) begin
            crc_q <= crc_d;
        end
    end

    assign crc32_out = crc_q ^ XOR_OUT;

endmodule

// File: tb/tb_crc32.sv
// Directed self-checking bench for crc32 against well-known CRC-32 check values.
module tb_crc32;

    logic        clk;
    logic        rst_n;
    logic [7:0]  crc32_in;
    logic        crc32_valid_in;
    logic [31:0] crc32_out;

    int unsigned n_checks;
    int unsigned n_pass;

    crc32 #(
        .POLY   (32'hEDB88320),
        .INIT   (32'hFFFFFFFF),
        .XOR_OUT(32'hFFFFFFFF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .crc32_in      (crc32_in),
        .crc32_valid_in(crc32_valid_in),
        .crc32_out     (crc32_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic do_reset(input logic valid_during, input logic [7:0] data_during);
        rst_n          = 1'b0;
        crc32_valid_in = valid_during;
        crc32_in       = data_during;
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        crc32_valid_in = 1'b0;
        crc32_in       = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        crc32_valid_in = 1'b1;
        crc32_in       = b;
        @(posedge clk);
        #1;
        crc32_valid_in = 1'b0;
        crc32_in       = 8'hA5;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            crc32_in = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_str(input string s, input int unsigned max_gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (max_gap != 0) idle($urandom_range(max_gap, 0));
        end
    endtask

    initial begin
        string fox;
        fox            = "The quick brown fox jumps over the lazy dog";
        n_checks       = 0;
        n_pass         = 0;
        rst_n          = 1'b1;
        crc32_valid_in = 1'b0;
        crc32_in       = 8'h00;

        do_reset(1'b0, 8'h00);
        check("reset_value", crc32_out, 32'h00000000);

        send_byte(8'h61);
        check("single_a", crc32_out, 32'hE8B7BE43);

        do_reset(1'b0, 8'h00);
        send_str("123456789", 0);
        check("check_123456789", crc32_out, 32'hCBF43926);

        idle(4);
        check("hold_idle_garbage", crc32_out, 32'hCBF43926);

        do_reset(1'b0, 8'h00);
        check("reset_after_stream", crc32_out, 32'h00000000);
        send_str("0123456789", 0);
        check("digits_0123456789", crc32_out, 32'hA684C7C6);

        do_reset(1'b0, 8'h00);
        for (int i = 0; i < 32; i++) send_byte(8'h00);
        check("zeros_32", crc32_out, 32'h190A55AD);

        do_reset(1'b0, 8'h00);
        for (int i = 0; i < 32; i++) send_byte(8'hFF);
        check("ones_32", crc32_out, 32'hFF6CAB0B);

        do_reset(1'b0, 8'h00);
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        check("ascending_32", crc32_out, 32'h91267E8A);

        do_reset(1'b0, 8'h00);
        send_str(fox, 0);
        check("fox_b2b", crc32_out, 32'h414FA339);

        do_reset(1'b0, 8'h00);
        send_str(fox, 3);
        check("fox_gapped", crc32_out, 32'h414FA339);

        do_reset(1'b0, 8'h00);
        send_str("01234", 0);
        do_reset(1'b1, 8'h55);
        check("midstream_reset", crc32_out, 32'h00000000);
        send_str("0123456789", 0);
        check("restart_digits", crc32_out, 32'hA684C7C6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/crc32.md
Name: crc32

Overview:
- Byte-serial CRC-32 accumulator (IEEE 802.3 / gzip / zlib CRC) used by the GZIP block to compute the trailer CRC over the uncompressed stream.
- Accepts one byte per clock when qualified by a valid strobe and maintains a running CRC register.
- Presents the finalized (complemented) CRC continuously on its output.
- Cleared between streams by reset only.

Parameters:
- POLY, 32'hEDB88320, reflected CRC-32 generator polynomial (0x04C11DB7 bit-reversed).
- INIT, 32'hFFFFFFFF, value loaded into the internal CRC register on reset.
- XOR_OUT, 32'hFFFFFFFF, value XORed onto the internal register to form the output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- crc32_in  input  8  data byte to absorb.
- crc32_valid_in  input  1  byte qualifier; crc32_in is absorbed on a rising edge when high.
- crc32_out  output  32  running finalized CRC: internal register XOR XOR_OUT.

Behaviour:
- Single clock clk. Reset is synchronous and active-low on rst_n, sampled only at the rising edge of clk.
- State: one 32-bit register crc_q.
- Reset: rst_n low at a rising edge loads crc_q <= INIT. Reset has priority over crc32_valid_in.
- Reset output value: crc32_out = INIT ^ XOR_OUT = 32'h00000000.
- Update: at a rising edge with rst_n high and crc32_valid_in high, crc_q <= next(crc_q, crc32_in).
- Hold: with crc32_valid_in low, crc_q holds its value. Idle cycles between bytes do not affect the result.
- next() is reflected (LSB-first) bitwise CRC, unrolled combinationally over 8 steps. Starting with c = crc_q, for bit i = 0..7 of the data byte:
  - fb = c[0] ^ d[i]
  - c = (c >> 1) ^ (fb ? POLY : 0)
  - result = c
- A table-driven or XOR-matrix implementation is acceptable if it is bit-exact.
- Output: crc32_out = crc_q ^ XOR_OUT, purely combinational from the register, with no additional pipeline stage.
- Latency: crc32_out reflects byte N immediately after the rising edge that absorbs it, i.e. one edge after crc32_valid_in/crc32_in are presented, and is stable well before the next edge.
- Back-to-back bytes: valid high on consecutive cycles absorbs one byte per cycle, at full throughput.
- No internal byte counter and no end-of-stream input. The consumer samples crc32_out after the last byte.
- A new stream requires asserting rst_n low for at least one rising edge.
- Reset mid-stream discards all accumulated state. A byte presented in the same cycle as reset is dropped.
- No X propagation: crc32_in is ignored when crc32_valid_in is low.

Test Plan:
- Reset: rst_n low for ≥1 edge, no data -> crc32_out = 32'h00000000.
- ASCII "0123456789", one byte per cycle -> crc32_out = 32'hA684C7C6 one edge after the last byte. "123456789" -> 32'hCBF43926.
- Reset between streams (each stream below starts after a reset):
  - 32 bytes of 8'h00 -> 32'h190A55AD.
  - 32 bytes of 8'hFF -> 32'hFF6CAB0B.
- Reset, bytes 8'h00..8'h1F ascending -> 32'h91267E8A.
- Reset, "The quick brown fox jumps over the lazy dog" (43 bytes) -> 32'h414FA339. Repeat with random idle gaps (valid low) inserted -> identical result.
- Reset asserted mid-stream with valid high -> crc32_out = 0 next edge. Restarting "0123456789" -> 32'hA684C7C6, proving no residue from the aborted stream.
